// File: rtl/id_ex_pkg.sv
// Shared encodings for the ID->EX boundary: control-bit layout, R-type funct
// codes of the special ops, and the decoded special-op tag.
package id_ex_pkg;
  localparam int CTRL_W     = 9;
  localparam int C_ALUSRC   = 8;
  localparam int C_MEMTOREG = 7;
  localparam int C_REGWRITE = 6;
  localparam int C_MEMREAD  = 5;
  localparam int C_MEMWRITE = 4;
  localparam int C_BRANCH   = 3;
  localparam int C_JUMP     = 2;
  localparam int C_ALUOP_HI = 1;
  localparam int C_ALUOP_LO = 0;

  localparam logic [5:0] FN_JR   = 6'd8;
  localparam logic [5:0] FN_DIVU = 6'd27;
  localparam logic [5:0] FN_MFHI = 6'd16;
  localparam logic [5:0] FN_MFLO = 6'd18;

  typedef enum logic [2:0] {
    SP_NONE, SP_NOP, SP_JR, SP_DIVU, SP_MFHI, SP_MFLO
  } spec_op_t;
endpackage

// File: rtl/id_ex_decode.sv
// Special-op decode: rewrites the ID control word for NOP/JR/DIVU/MFHI/MFLO
// and raises the matching one-hot flag. Purely combinational.
module id_ex_decode
  import id_ex_pkg::*;
(
  input  logic [31:0]       instr_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic              jr_o,
  output logic              div_o,
  output logic              hi_o,
  output logic              lo_o,
  output spec_op_t          op_o
);
  logic       rtype;
  logic [5:0] funct;

  assign rtype = (instr_i[31:26] == 6'd0);
  assign funct = instr_i[5:0];

  always_comb begin
    ctrl_o = ctrl_i;
    jr_o   = 1'b0;
    div_o  = 1'b0;
    hi_o   = 1'b0;
    lo_o   = 1'b0;
    op_o   = SP_NONE;
    // Priority order matters: an all-zero word is a NOP even though it is R-type.
    if (instr_i == 32'd0) begin
      ctrl_o = '0;
      op_o   = SP_NOP;
    end else if (rtype && funct == FN_JR) begin
      ctrl_o             = '0;
      ctrl_o[C_ALUOP_LO] = 1'b1;
      jr_o               = 1'b1;
      op_o               = SP_JR;
    end else if (rtype && funct == FN_DIVU) begin
      ctrl_o = '0;
      div_o  = 1'b1;
      op_o   = SP_DIVU;
    end else if (rtype && funct == FN_MFHI) begin
      ctrl_o             = '0;
      ctrl_o[C_REGWRITE] = 1'b1;
      hi_o               = 1'b1;
      op_o               = SP_MFHI;
    end else if (rtype && funct == FN_MFLO) begin
      ctrl_o             = '0;
      ctrl_o[C_REGWRITE] = 1'b1;
      lo_o               = 1'b1;
      op_o               = SP_MFLO;
    end
  end
endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID->EX pipeline register: output slot plus one skid slot under valid/ready,
// flush squash, and a HI/LO busy counter that holds MFHI/MFLO behind a DIVU.
module id_ex_pipe_reg
  import id_ex_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int DIV_LAT = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_pc,
  input  logic [DATA_W-1:0] in_rd1,
  input  logic [DATA_W-1:0] in_rd2,
  input  logic [DATA_W-1:0] in_immed,
  input  logic [DATA_W-1:0] in_jump_addr,
  input  logic [4:0]        in_shamt,
  input  logic [REG_AW-1:0] in_wn,
  input  logic [31:0]       in_instr,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_pc,
  output logic [DATA_W-1:0] out_rd1,
  output logic [DATA_W-1:0] out_rd2,
  output logic [DATA_W-1:0] out_immed,
  output logic [DATA_W-1:0] out_jump_addr,
  output logic [4:0]        out_shamt,
  output logic [REG_AW-1:0] out_wn,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic              out_jr,
  output logic              out_div,
  output logic              out_hi,
  output logic              out_lo,
  output logic              hilo_busy
);
  localparam int CNT_W = $clog2(DIV_LAT + 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT);

  typedef struct packed {
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [DATA_W-1:0] immed;
    logic [DATA_W-1:0] jaddr;
    logic [4:0]        shamt;
    logic [REG_AW-1:0] wn;
    logic [CTRL_W-1:0] ctrl;
    logic              jr;
    logic              div;
    logic              hi;
    logic              lo;
  } entry_t;

  entry_t            in_e, out_q, out_d, skid_q, skid_d;
  logic              out_vld_q, out_vld_d, skid_full_q, skid_full_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CTRL_W-1:0] dec_ctrl;
  logic              dec_jr, dec_div, dec_hi, dec_lo;
  spec_op_t          dec_op;
  logic              hazard, accept, deliver;

  id_ex_decode u_dec (
    .instr_i (in_instr),
    .ctrl_i  (in_ctrl),
    .ctrl_o  (dec_ctrl),
    .jr_o    (dec_jr),
    .div_o   (dec_div),
    .hi_o    (dec_hi),
    .lo_o    (dec_lo),
    .op_o    (dec_op)
  );

  assign in_e = '{pc: in_pc, rd1: in_rd1, rd2: in_rd2, immed: in_immed,
                  jaddr: in_jump_addr, shamt: in_shamt, wn: in_wn,
                  ctrl: dec_ctrl, jr: dec_jr, div: dec_div, hi: dec_hi, lo: dec_lo};

  assign hilo_busy = (cnt_q != '0);
  assign hazard    = hilo_busy && (dec_op == SP_MFHI || dec_op == SP_MFLO);
  assign in_ready  = !skid_full_q && !hazard;
  assign accept    = in_valid && in_ready;
  assign deliver   = out_vld_q && out_ready;

  always_comb begin
    out_d       = out_q;
    skid_d      = skid_q;
    out_vld_d   = out_vld_q;
    skid_full_d = skid_full_q;
    cnt_d       = hilo_busy ? cnt_q - CNT_W'(1) : cnt_q;
    // A squashed DIVU never issues, so it must not start the counter.
    if (accept && dec_div && !flush)
      cnt_d = DIV_LOAD;
    if (flush) begin
      out_vld_d   = 1'b0;
      skid_full_d = 1'b0;
    end else if (!out_vld_q || deliver) begin
      if (skid_full_q) begin
        out_d       = skid_q;
        out_vld_d   = 1'b1;
        skid_full_d = 1'b0;
      end else begin
        out_vld_d = accept;
        if (accept) out_d = in_e;
      end
    end else if (accept) begin
      skid_d      = in_e;
      skid_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_q       <= '0;
      skid_q      <= '0;
      out_vld_q   <= 1'b0;
      skid_full_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      out_q       <= out_d;
      skid_q      <= skid_d;
      out_vld_q   <= out_vld_d;
      skid_full_q <= skid_full_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid     = out_vld_q;
  assign out_pc        = out_q.pc;
  assign out_rd1       = out_q.rd1;
  assign out_rd2       = out_q.rd2;
  assign out_immed     = out_q.immed;
  assign out_jump_addr = out_q.jaddr;
  assign out_shamt     = out_q.shamt;
  assign out_wn        = out_q.wn;
  assign out_ctrl      = out_q.ctrl;
  assign out_jr        = out_q.jr;
  assign out_div       = out_q.div;
  assign out_hi        = out_q.hi;
  assign out_lo        = out_q.lo;
endmodule
